// File: rtl/fifo_pkg.sv
// Shared async-FIFO types and helpers: pointer type, depth and gray/binary conversions.
// Both conversion functions work on any pointer width up to 32 bits.
package fifo_pkg;

  localparam int unsigned FIFO_ADDR_WIDTH = 3;
  localparam int unsigned DEPTH           = 2 ** FIFO_ADDR_WIDTH;

  typedef logic [FIFO_ADDR_WIDTH:0] ptr_t;

  function automatic logic [31:0] width_mask(input int unsigned width);
    return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] bin, input int unsigned width);
    logic [31:0] b;
    b = bin & width_mask(width);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all gray bits at and above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray, input int unsigned width);
    logic [31:0] g;
    logic [31:0] b;
    g = gray & width_mask(width);
    b = g;
    for (int i = 1; i < 32; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// Generic STAGES x WIDTH synchronizer for gray-coded pointers crossing a clock boundary.
// Synchronous active-low reset; a plain shift chain with no logic between stages.
module gray_ptr_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/wptr_full_sync.sv
// Write-domain full-flag generator: synchronizes the read gray pointer and registers full.
// Optional fill level / almost-full outputs are built when FIFO_WLEVEL_EN is defined.
module wptr_full_sync
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH         = FIFO_ADDR_WIDTH,
  parameter int SYNC_STAGES        = 2,
  parameter int ALMOST_FULL_MARGIN = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [ADDR_WIDTH:0] i_rptr_gray,
  input  logic [ADDR_WIDTH:0] i_wgray_next,
  output logic [ADDR_WIDTH:0] o_rptr_sync,
  output logic                o_full,
  output logic [ADDR_WIDTH:0] o_level,
  output logic                o_almost_full
);

  logic [ADDR_WIDTH:0] rq;
  logic                full_nxt;

  gray_ptr_sync #(
    .WIDTH  (ADDR_WIDTH + 1),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_rptr_gray),
    .o_q     (rq)
  );

  assign o_rptr_sync = rq;

  // Full when write is exactly one lap ahead: top two gray bits inverted, rest equal.
  assign full_nxt = (i_wgray_next == {~rq[ADDR_WIDTH:ADDR_WIDTH-1], rq[ADDR_WIDTH-2:0]});

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_full <= 1'b0;
    end else begin
      o_full <= full_nxt;
    end
  end

`ifdef FIFO_WLEVEL_EN
  typedef logic [ADDR_WIDTH:0] ptr_w_t;

  localparam ptr_w_t AF_THRESH = ptr_w_t'((2 ** ADDR_WIDTH) - ALMOST_FULL_MARGIN);

  ptr_w_t wbin;
  ptr_w_t rbin;
  ptr_w_t level_nxt;

  always_comb begin
    wbin      = ptr_w_t'(gray2bin(32'(i_wgray_next), ADDR_WIDTH + 1));
    rbin      = ptr_w_t'(gray2bin(32'(rq), ADDR_WIDTH + 1));
    level_nxt = wbin - rbin;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_level       <= '0;
      o_almost_full <= 1'b0;
    end else begin
      o_level       <= level_nxt;
      o_almost_full <= (level_nxt >= AF_THRESH);
    end
  end
`else
  assign o_level       = '0;
  assign o_almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_full_sync.sv
// Self-checking bench for wptr_full_sync (ADDR_WIDTH=3, SYNC_STAGES=2, margin 2).
// Directed scenarios plus a randomized run against an arithmetic occupancy model.
module tb_wptr_full_sync;
  import fifo_pkg::*;

  localparam int AW   = 3;
  localparam int SYNC = 2;
  localparam int MARG = 2;

  logic       clk;
  logic       rst_n;
  logic [3:0] rptr;
  logic [3:0] wnext;
  logic [3:0] rq;
  logic       full;
  logic [3:0] level;
  logic       afull;

  int n_checks;
  int n_fail;

  // model state: what the outputs should show after the latest edge
  logic [3:0] m_rq;
  logic       m_full;
  logic [3:0] m_level;
  logic       m_af;
  logic [3:0] rhist[$];

  wptr_full_sync #(
    .ADDR_WIDTH         (AW),
    .SYNC_STAGES        (SYNC),
    .ALMOST_FULL_MARGIN (MARG)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_rptr_gray   (rptr),
    .i_wgray_next  (wnext),
    .o_rptr_sync   (rq),
    .o_full        (full),
    .o_level       (level),
    .o_almost_full (afull)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] to_gray(input int b);
    int v;
    v = b % 16;
    return 4'(v ^ (v >> 1));
  endfunction

  function automatic int to_bin(input logic [3:0] g);
    int b;
    b = 0;
    for (int i = 3; i >= 0; i--) begin
      b = b * 2 + (((b % 2) ^ int'(g[i])) & 1);
    end
    return b;
  endfunction

  // Occupancy = write count minus the (stale) read count, modulo one full pointer lap.
  task automatic tick();
    int occ;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      rhist.delete();
      m_rq = 4'h0; m_full = 1'b0; m_level = 4'h0; m_af = 1'b0;
    end else begin
      occ    = (to_bin(wnext) + 16 - to_bin(m_rq)) % 16;
      m_full = (occ == DEPTH);
`ifdef FIFO_WLEVEL_EN
      m_level = 4'(occ);
      m_af    = (occ >= DEPTH - MARG);
`else
      m_level = 4'h0;
      m_af    = 1'b0;
`endif
      rhist.push_back(rptr);
      m_rq = (rhist.size() >= SYNC) ? rhist[rhist.size() - SYNC] : 4'h0;
      if (rhist.size() > 8) void'(rhist.pop_front());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rptr = 4'hA; wnext = 4'h6;
    tick(); tick();
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
    n_checks++; if (rq !== 4'h0) begin n_fail++; $display("FAIL reset_rq got %b want 0000", rq); end
    n_checks++; if (level !== 4'h0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
    n_checks++; if (afull !== 1'b0) begin n_fail++; $display("FAIL reset_afull got %b want 0", afull); end
    rptr = 4'h0; wnext = 4'h0; rst_n = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic test_sync_latency();
    rptr = 4'b0001;
    tick();
    n_checks++; if (rq !== 4'b0000) begin n_fail++; $display("FAIL sync_early1 got %b want 0000", rq); end
    tick();
    n_checks++; if (rq !== 4'b0001) begin n_fail++; $display("FAIL sync_at2 got %b want 0001", rq); end
    tick();
    n_checks++; if (rq !== 4'b0001) begin n_fail++; $display("FAIL sync_hold got %b want 0001", rq); end
  endtask

  task automatic test_full_detect();
    rptr = 4'b0000; wnext = 4'b0000;
    tick(); tick(); tick();
    for (int k = 1; k <= 8; k++) begin
      wnext = to_gray(k);
      tick();
      n_checks++;
      if (full !== (k == 8)) begin
        n_fail++; $display("FAIL full_step k=%0d got %b want %b", k, full, (k == 8));
      end
    end
    n_checks++; if (wnext !== 4'b1100) begin n_fail++; $display("FAIL gray8 got %b want 1100", wnext); end
  endtask

  task automatic test_full_release();
    rptr = 4'b0001;
    tick();
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL release_e1 got %b want 1", full); end
    tick();
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL release_e2 got %b want 1", full); end
    tick();
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL release_e3 got %b want 0", full); end
  endtask

  task automatic test_wrap();
    rptr = 4'b1010; wnext = 4'b0110;
    tick(); tick(); tick();
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL wrap_full got %b want 1", full); end
    rptr = 4'b0110;
    tick(); tick(); tick();
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL wrap_empty got %b want 0", full); end
  endtask

  task automatic test_level();
    rptr = to_gray(1); wnext = to_gray(6);
    tick(); tick(); tick();
`ifdef FIFO_WLEVEL_EN
    n_checks++; if (level !== 4'd5) begin n_fail++; $display("FAIL level5 got %0d want 5", level); end
    n_checks++; if (afull !== 1'b0) begin n_fail++; $display("FAIL af_at5 got %b want 0", afull); end
    wnext = to_gray(7);
    tick();
    n_checks++; if (level !== 4'd6) begin n_fail++; $display("FAIL level6 got %0d want 6", level); end
    n_checks++; if (afull !== 1'b1) begin n_fail++; $display("FAIL af_at6 got %b want 1", afull); end
    wnext = to_gray(9);
    tick();
    n_checks++; if (level !== 4'd8 || full !== 1'b1) begin
      n_fail++; $display("FAIL level_full_agree got level=%0d full=%b want 8/1", level, full);
    end
`else
    n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL level_tied got %0d want 0", level); end
    n_checks++; if (afull !== 1'b0) begin n_fail++; $display("FAIL af_tied got %b want 0", afull); end
`endif
  endtask

  task automatic test_reset_while_full();
    rptr = 4'b0000; wnext = 4'b1100;
    tick(); tick(); tick();
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL pre_reset_full got %b want 1", full); end
    rst_n = 1'b0;
    tick();
    n_checks++; if (full !== 1'b0 || rq !== 4'h0 || level !== 4'h0 || afull !== 1'b0) begin
      n_fail++; $display("FAIL midreset got full=%b rq=%b level=%0d af=%b want all 0", full, rq, level, afull);
    end
    rptr = 4'b0011; rst_n = 1'b1;
    tick();
    n_checks++; if (rq !== 4'h0) begin n_fail++; $display("FAIL reacq_e1 got %b want 0000", rq); end
    tick();
    n_checks++; if (rq !== 4'b0011) begin n_fail++; $display("FAIL reacq_e2 got %b want 0011", rq); end
  endtask

  task automatic test_random();
    int rb;
    int wb;
    rb = to_bin(rptr);
    wb = rb;
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(0, 3))
        0: rb = (rb + 1) % 16;
        1: wb = (wb + 1) % 16;
        2: begin rb = (rb + 1) % 16; wb = (wb + 1) % 16; end
        default: if ($urandom_range(0, 3) == 0) wb = (rb + 8) % 16;
      endcase
      rptr = to_gray(rb); wnext = to_gray(wb);
      tick();
      n_checks++;
      if (rq !== m_rq || full !== m_full || level !== m_level || afull !== m_af) begin
        n_fail++;
        $display("FAIL random c=%0d got rq=%b full=%b lvl=%0d af=%b want rq=%b full=%b lvl=%0d af=%b",
                 c, rq, full, level, afull, m_rq, m_full, m_level, m_af);
      end
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    m_rq = 4'h0; m_full = 1'b0; m_level = 4'h0; m_af = 1'b0;
    rst_n = 1'b0; rptr = 4'h0; wnext = 4'h0;
    test_reset();
    test_sync_latency();
    test_full_detect();
    test_full_release();
    test_wrap();
    test_level();
    test_reset_while_full();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
